epwm_time_base: RTL and testbench

Parametrised EPWM time-base counter: the successor to the single-mode wrap-around timer. It adds:
- up, down and up-down count modes
- a clock prescaler
- a period shadow register
- a phase-load sync input
- direction, zero-event and period-event outputs

It sits at the front of each EPWM channel and feeds the compare and action-qualifier logic.

---
 rtl/epwm_pkg.sv | 15 +
 rtl/epwm_time_base_if.sv | 32 +++
 rtl/epwm_prescaler.sv | 28 ++
 rtl/epwm_time_base.sv | 115 +++++++++++
 tb/tb_epwm_time_base.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/epwm_pkg.sv
// Shared definitions for the EPWM time-base: count-mode encodings, direction
// levels and the 2-bit mode type used on the channel interface.
package epwm_pkg;

   typedef logic [1:0] tb_mode_t;

   localparam tb_mode_t TB_UP     = 2'd0;
   localparam tb_mode_t TB_DOWN   = 2'd1;
   localparam tb_mode_t TB_UPDOWN = 2'd2;
   localparam tb_mode_t TB_FREEZE = 2'd3;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/epwm_time_base_if.sv
// Channel-side bundle of the time-base: configuration/control in, count and
// event outputs back. The master modport drives control; slave is the counter.
interface epwm_time_base_if
   import epwm_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int PRESCALE_W = 4
) ();

   logic                  enable;
   tb_mode_t              mode;
   logic [WIDTH-1:0]      period;
   logic [PRESCALE_W-1:0] prescale;
   logic [WIDTH-1:0]      phase;
   logic                  sync_in;
   logic [WIDTH-1:0]      count;
   logic                  dir;
   logic                  zero_evt;
   logic                  period_evt;
   logic                  sync_out;

   modport master (
      output enable, mode, period, prescale, phase, sync_in,
      input  count, dir, zero_evt, period_evt, sync_out
   );

   modport slave (
      input  enable, mode, period, prescale, phase, sync_in,
      output count, dir, zero_evt, period_evt, sync_out
   );

endinterface

// File: rtl/epwm_prescaler.sv
// Clock divider for the time-base: emits a one-cycle tick every prescale+1
// enabled cycles, restarting from zero when disabled or cleared.
module epwm_prescaler #(
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable_i,
   input  logic                  clear_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   output logic                  tick_o
);

   logic [PRESCALE_W-1:0] div_q;

   // >= rather than == so a prescale shrunk below the divider still ticks at once
   assign tick_o = enable_i && !clear_i && (div_q >= prescale_i);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         div_q <= '0;
      else if (!enable_i || clear_i || tick_o)
         div_q <= '0;
      else
         div_q <= div_q + PRESCALE_W'(1);
   end

endmodule

// File: rtl/epwm_time_base.sv
// EPWM time-base counter: up / down / up-down counting with prescaler, phase sync
// and zero/period events. Define EPWM_TB_SHADOW_EN to buffer the period in a shadow.
module epwm_time_base
   import epwm_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int PRESCALE_W = 4
) (
   input logic               clk,
   input logic               reset,
   epwm_time_base_if.slave   tb_io
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             zeroEvt_q, zeroEvt_d;
   logic             periodEvt_q, periodEvt_d;
   logic [WIDTH-1:0] activePeriod;
   logic             tick;
   logic             syncLoad;

   assign syncLoad = tb_io.enable && tb_io.sync_in;

   epwm_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk        (clk),
      .reset      (reset),
      .enable_i   (tb_io.enable),
      .clear_i    (tb_io.sync_in),
      .prescale_i (tb_io.prescale),
      .tick_o     (tick)
   );

`ifdef EPWM_TB_SHADOW_EN
   logic [WIDTH-1:0] period_q;
   logic             shadowLoad;

   // A tick leaving zero both reloads the shadow and counts with the new value
   assign shadowLoad   = tick && (count_q == '0);
   assign activePeriod = shadowLoad ? tb_io.period : period_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         period_q <= '0;
      else if (!tb_io.enable || shadowLoad)
         period_q <= tb_io.period;
   end
`else
   assign activePeriod = tb_io.period;
`endif

   // Boundaries are tested before +/-1, so the counter never wraps through 2^WIDTH
   always_comb begin
      count_d     = count_q;
      dir_d       = dir_q;
      zeroEvt_d   = 1'b0;
      periodEvt_d = 1'b0;
      if (syncLoad) begin
         count_d = (tb_io.phase > activePeriod) ? activePeriod : tb_io.phase;
         dir_d   = DIR_UP;
      end else if (tick && (tb_io.mode != TB_FREEZE)) begin
         case (tb_io.mode)
            TB_UP: begin
               count_d = (count_q >= activePeriod) ? '0 : count_q + WIDTH'(1);
               dir_d   = DIR_UP;
            end
            TB_DOWN: begin
               count_d = (count_q == '0) ? activePeriod : count_q - WIDTH'(1);
               dir_d   = DIR_DOWN;
            end
            default: begin
               if (count_q > activePeriod) begin
                  count_d = activePeriod;
                  dir_d   = DIR_DOWN;
               end else begin
                  if (dir_q == DIR_UP)
                     count_d = (count_q < activePeriod) ? count_q + WIDTH'(1) :
                               (count_q == '0)          ? '0 : count_q - WIDTH'(1);
                  else
                     count_d = (count_q != '0)         ? count_q - WIDTH'(1) :
                               (activePeriod == '0)    ? '0 : count_q + WIDTH'(1);
                  if (count_d == '0)
                     dir_d = DIR_UP;
                  else if (count_d == activePeriod)
                     dir_d = DIR_DOWN;
                  else
                     dir_d = (count_d > count_q);
               end
            end
         endcase
         zeroEvt_d   = (count_d == '0);
         periodEvt_d = (count_d == activePeriod);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q     <= '0;
         dir_q       <= DIR_UP;
         zeroEvt_q   <= 1'b0;
         periodEvt_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         dir_q       <= dir_d;
         zeroEvt_q   <= zeroEvt_d;
         periodEvt_q <= periodEvt_d;
      end
   end

   assign tb_io.count      = count_q;
   assign tb_io.dir        = dir_q;
   assign tb_io.zero_evt   = zeroEvt_q;
   assign tb_io.period_evt = periodEvt_q;
   assign tb_io.sync_out   = zeroEvt_q;

endmodule

// File: tb/tb_epwm_time_base.sv
// Directed testbench for epwm_time_base; expected sequences are hand-derived
// per scenario. Shadow-period expectations follow EPWM_TB_SHADOW_EN.
module tb_epwm_time_base;
   import epwm_pkg::*;

   localparam int WIDTH      = 16;
   localparam int PRESCALE_W = 4;
   localparam int VW         = WIDTH + 4;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   epwm_time_base_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) tbIf ();

   epwm_time_base #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
      .clk   (clk),
      .reset (reset),
      .tb_io (tbIf)
   );

   always #5 clk = ~clk;

   // Expected output vector {count, dir, zero_evt, period_evt, sync_out}
   function automatic logic [VW-1:0] pack(input int c, input bit d, input bit z, input bit p);
      logic [WIDTH-1:0] cw;
      cw = c[WIDTH-1:0];
      return {cw, d, z, p, z};
   endfunction

   function automatic logic [VW-1:0] observed();
      return {tbIf.count, tbIf.dir, tbIf.zero_evt, tbIf.period_evt, tbIf.sync_out};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input tb_mode_t m, input int p, input int pre);
      tbIf.enable   = 1'b1;
      tbIf.sync_in  = 1'b0;
      tbIf.phase    = '0;
      tbIf.mode     = m;
      tbIf.period   = p[WIDTH-1:0];
      tbIf.prescale = pre[PRESCALE_W-1:0];
   endtask

   task automatic restart(input tb_mode_t m, input int p, input int pre);
      reset = 1'b1;
      applyStimulus(m, p, pre);
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [VW-1:0] exp;
      reset = 1'b1;
      applyStimulus(TB_UP, 4, 0);
      #12;
      exp = pack(0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("[TB] FAIL reset_state: got %h expected %h", observed(), exp);
      end
   endtask

   task automatic test_up();
      logic [VW-1:0] exp;
      int c;
      restart(TB_UP, 4, 0);
      for (int i = 0; i < 10; i++) begin
         step();
         c   = (i + 1) % 5;
         exp = pack(c, 1'b1, c == 0, c == 4);
         checks++;
         if (observed() !== exp) begin
            errors++;
            $display("[TB] FAIL up_step%0d: got %h expected %h", i, observed(), exp);
         end
      end
   endtask

   task automatic test_updown();
      int expC [14];
      bit expD [14];
      logic [VW-1:0] exp;
      expC = '{0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0, 1};
      expD = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};
      restart(TB_UPDOWN, 3, 1);
      for (int i = 0; i < 14; i++) begin
         step();
         exp = pack(expC[i], expD[i], i == 11, i == 5);
         checks++;
         if (observed() !== exp) begin
            errors++;
            $display("[TB] FAIL updown_step%0d: got %h expected %h", i, observed(), exp);
         end
      end
   endtask

   task automatic test_down();
      int expC [7];
      logic [VW-1:0] exp;
      expC = '{5, 4, 3, 2, 1, 0, 5};
      restart(TB_DOWN, 5, 0);
      for (int i = 0; i < 7; i++) begin
         step();
         exp = pack(expC[i], 1'b0, expC[i] == 0, expC[i] == 5);
         checks++;
         if (observed() !== exp) begin
            errors++;
            $display("[TB] FAIL down_step%0d: got %h expected %h", i, observed(), exp);
         end
      end
   endtask

   task automatic test_sync();
      logic [VW-1:0] exp [5];
      logic [VW-1:0] got [5];
      restart(TB_UP, 10, 1);
      for (int i = 0; i < 6; i++) step();
      got[0] = observed();
      exp[0] = pack(3, 1'b1, 1'b0, 1'b0);
      tbIf.phase   = 16'd7;
      tbIf.sync_in = 1'b1;
      step();
      got[1] = observed();
      exp[1] = pack(7, 1'b1, 1'b0, 1'b0);
      tbIf.sync_in = 1'b0;
      step();
      got[2] = observed();
      exp[2] = pack(7, 1'b1, 1'b0, 1'b0);
      step();
      got[3] = observed();
      exp[3] = pack(8, 1'b1, 1'b0, 1'b0);
      tbIf.phase   = 16'd20;
      tbIf.sync_in = 1'b1;
      step();
      got[4] = observed();
      exp[4] = pack(10, 1'b1, 1'b0, 1'b0);
      tbIf.sync_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin
            errors++;
            $display("[TB] FAIL sync_%0d: got %h expected %h", i, got[i], exp[i]);
         end
      end
   endtask

   task automatic test_shadow();
      int expC [8];
      bit expP [8];
      logic [VW-1:0] exp;
`ifdef EPWM_TB_SHADOW_EN
      expC = '{6, 7, 8, 0, 1, 2, 3, 0};
      expP = '{0, 0, 1, 0, 0, 0, 1, 0};
`else
      expC = '{0, 1, 2, 3, 0, 1, 2, 3};
      expP = '{0, 0, 0, 1, 0, 0, 0, 1};
`endif
      restart(TB_UP, 8, 0);
      for (int i = 0; i < 5; i++) step();
      exp = pack(5, 1'b1, 1'b0, 1'b0);
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("[TB] FAIL shadow_pre: got %h expected %h", observed(), exp);
      end
      tbIf.period = 16'd3;
      for (int i = 0; i < 8; i++) begin
         step();
         exp = pack(expC[i], 1'b1, expC[i] == 0, expP[i]);
         checks++;
         if (observed() !== exp) begin
            errors++;
            $display("[TB] FAIL shadow_step%0d: got %h expected %h", i, observed(), exp);
         end
      end
   endtask

   task automatic test_pzero();
      tb_mode_t modes [3];
      bit       dirs  [3];
      logic [VW-1:0] exp;
      modes = '{TB_UP, TB_DOWN, TB_UPDOWN};
      dirs  = '{1'b1, 1'b0, 1'b1};
      for (int m = 0; m < 3; m++) begin
         restart(modes[m], 0, 0);
         for (int i = 0; i < 3; i++) begin
            step();
            exp = pack(0, dirs[m], 1'b1, 1'b1);
            checks++;
            if (observed() !== exp) begin
               errors++;
               $display("[TB] FAIL pzero_m%0d_s%0d: got %h expected %h", m, i, observed(), exp);
            end
         end
      end
   endtask

   task automatic test_enable_freeze();
      logic [VW-1:0] exp [5];
      logic [VW-1:0] got [5];
      restart(TB_UP, 4, 0);
      step();
      step();
      tbIf.enable = 1'b0;
      step();
      step();
      got[0] = observed();
      exp[0] = pack(2, 1'b1, 1'b0, 1'b0);
      tbIf.enable = 1'b1;
      step();
      got[1] = observed();
      exp[1] = pack(3, 1'b1, 1'b0, 1'b0);
      tbIf.mode = TB_FREEZE;
      step();
      step();
      got[2] = observed();
      exp[2] = pack(3, 1'b1, 1'b0, 1'b0);
      tbIf.mode = TB_UP;
      step();
      got[3] = observed();
      exp[3] = pack(4, 1'b1, 1'b0, 1'b1);
      tbIf.mode = TB_DOWN;
      step();
      got[4] = observed();
      exp[4] = pack(3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin
            errors++;
            $display("[TB] FAIL enable_freeze_%0d: got %h expected %h", i, got[i], exp[i]);
         end
      end
   endtask

   task automatic test_reset_midrun();
      logic [VW-1:0] exp [3];
      logic [VW-1:0] got [3];
      restart(TB_UP, 4, 0);
      for (int i = 0; i < 4; i++) step();
      got[0] = observed();
      exp[0] = pack(4, 1'b1, 1'b0, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      got[1] = observed();
      exp[1] = pack(0, 1'b1, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      step();
      got[2] = observed();
      exp[2] = pack(1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin
            errors++;
            $display("[TB] FAIL reset_midrun_%0d: got %h expected %h", i, got[i], exp[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_up();
      test_updown();
      test_down();
      test_sync();
      test_shadow();
      test_pzero();
      test_enable_freeze();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
